// File: rtl/rdi_pkg.sv
// Shared types and constants for the rdi_data receive path.
package rdi_pkg;

  typedef enum logic [0:0] {
    RX_IDLE,
    RX_ASSEMBLE
  } rx_state_t;

  localparam int unsigned RDI_BYTES_PER_WORD = 4;

  typedef logic [31:0] rdi_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is presented combinationally, zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A push into a full FIFO still succeeds when a pop frees the head slot in the same cycle.
  assign wr_en = push && (!full || (pop && !empty));
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/rdi_receiver.sv
// Assembles link bytes into little-endian words, buffers them and feeds the RDI instruction.
module rdi_receiver
  import rdi_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_byte_vld,
  input  logic                   rdi_mem,
  input  logic                   stallmem,
  input  logic                   err_clr,
  output logic [31:0]            rdi_data,
  output logic                   rdi_stall,
  output logic                   rdi_empty,
  output logic [$clog2(DEPTH):0] rdi_count,
  output logic                   rx_overflow,
  output logic                   rx_frame_err
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  rx_state_t          state;
  logic [1:0]         idx;
  logic [23:0]        shreg;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               push_q;
  rdi_word_t          word_q;
  logic               fifo_full;
  logic               pop;
  logic               timeout_hit;
  logic               overflow_set;

  assign pop          = rdi_mem && !stallmem && !rdi_empty;
  assign rdi_stall    = rdi_mem && rdi_empty;
  assign timeout_hit  = (state == RX_ASSEMBLE) && !rx_byte_vld && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign overflow_set = push_q && fifo_full && !pop;

  // Bytes shift in from the top, so after three bytes shreg holds {b2,b1,b0}.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RX_IDLE;
      idx          <= '0;
      shreg        <= '0;
      tmo_cnt      <= '0;
      push_q       <= 1'b0;
      word_q       <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_byte_vld) begin
            shreg   <= {rx_byte, shreg[23:8]};
            idx     <= 2'd1;
            tmo_cnt <= '0;
            state   <= RX_ASSEMBLE;
          end
        end
        RX_ASSEMBLE: begin
          if (rx_byte_vld) begin
            tmo_cnt <= '0;
            if (idx == 2'(RDI_BYTES_PER_WORD - 1)) begin
              word_q <= {rx_byte, shreg};
              push_q <= 1'b1;
              idx    <= '0;
              state  <= RX_IDLE;
            end else begin
              shreg <= {rx_byte, shreg[23:8]};
              idx   <= idx + 2'd1;
            end
          end else if (timeout_hit) begin
            tmo_cnt <= '0;
            idx     <= '0;
            state   <= RX_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
      rx_overflow  <= overflow_set || (rx_overflow && !err_clr);
      rx_frame_err <= timeout_hit || (rx_frame_err && !err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .din   (word_q),
    .dout  (rdi_data),
    .full  (fifo_full),
    .empty (rdi_empty),
    .count (rdi_count)
  );

endmodule
